// File: rtl/bitmap_pkg.sv
// Shared constants and types for the bitmap compressor and its decompression counterpart.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: element code/size constants, FSM state encoding, block geometry,
// and a helper that converts a payload bit count into a number of beats.
package bitmap_pkg;

    localparam int ELEMS_PER_BLOCK = 8;
    localparam int BEAT_W          = 32;
    localparam int ELEM_W          = 32;
    localparam int BITMAP_W        = 2 * ELEMS_PER_BLOCK;
    localparam int PACK_W          = ELEMS_PER_BLOCK * ELEM_W;
    localparam int PTR_W           = 9;

    // Per-element codes; 2'b01 is reserved and never emitted.
    localparam logic [1:0] CODE_ZERO = 2'b00;
    localparam logic [1:0] CODE_HALF = 2'b10;
    localparam logic [1:0] CODE_FULL = 2'b11;

    // Stored bits per element for each code.
    localparam logic [5:0] SIZE_ZERO = 6'd0;
    localparam logic [5:0] SIZE_HALF = 6'd16;
    localparam logic [5:0] SIZE_FULL = 6'd32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Number of 32-bit beats needed to carry 'bits' payload bits (0..256 -> 0..8).
    function automatic logic [3:0] beats_for_bits(input logic [PTR_W-1:0] bits);
        return 4'((bits + 9'd31) >> 5);
    endfunction

endpackage

// File: rtl/bitmap_code_classify.sv
// Classifies one 32-bit element into a 2-bit code, stored bit count and stored data.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake on this block.
//
// Ports: value (in, 32) element; code (out, 2) bitmap code; size (out, 6) stored
// bit count; stored (out, 32) bits to pack, zero-extended when only 16 are kept.
module bitmap_code_classify
    import bitmap_pkg::*;
(
    input  logic [31:0] value,
    output logic [1:0]  code,
    output logic [5:0]  size,
    output logic [31:0] stored
);

    always_comb begin
        code   = CODE_FULL;
        size   = SIZE_FULL;
        stored = value;
        if (value == 32'h0) begin
            code   = CODE_ZERO;
            size   = SIZE_ZERO;
            stored = 32'h0;
        end else if (value[31:16] == 16'h0) begin
            code   = CODE_HALF;
            size   = SIZE_HALF;
            stored = {16'h0, value[15:0]};
        end
    end

endmodule

// File: rtl/bitmap_compressor.sv
// Compresses blocks of 8 x 32-bit elements into a bitmap header beat plus packed payload beats.
// Latency: header is valid the cycle after the 8th element is accepted; one beat per accepted cycle.
// Backpressure: valid/ready on both sides; input stalls for the whole output phase, output holds while out_ready=0.
//
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data element stream;
// out_valid/out_ready/out_data/out_last beat stream (header first, last beat flagged).
module bitmap_compressor
    import bitmap_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last
);

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           elem_cnt;
    logic [PTR_W-1:0]     ptr;
    logic [BITMAP_W-1:0]  bitmap;
    logic [PACK_W-1:0]    packed_bits;
    logic [2:0]           beat_idx;

    logic [1:0]           cls_code;
    logic [5:0]           cls_size;
    logic [31:0]          cls_stored;
    logic [3:0]           n_beats;
    logic                 last_beat;

    bitmap_code_classify u_classify (
        .value  (in_data),
        .code   (cls_code),
        .size   (cls_size),
        .stored (cls_stored)
    );

    assign n_beats   = beats_for_bits(ptr);
    assign last_beat = ({1'b0, beat_idx} == (n_beats - 4'd1));

    // Next state and outputs; everything is forced low while rst is high.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 32'h0;
        if (!rst) begin
            case (state_q)
                COLLECT: begin
                    in_ready = 1'b1;
                    if (in_valid && (elem_cnt == 3'd7)) begin
                        state_d = HEADER;
                    end
                end
                HEADER: begin
                    out_valid = 1'b1;
                    out_data  = {16'h0000, bitmap};
                    out_last  = (ptr == '0);
                    if (out_ready) begin
                        state_d = (ptr == '0) ? COLLECT : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    out_valid = 1'b1;
                    out_data  = packed_bits[{beat_idx, 5'b00000} +: BEAT_W];
                    out_last  = last_beat;
                    if (out_ready && last_beat) begin
                        state_d = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            elem_cnt    <= '0;
            ptr         <= '0;
            bitmap      <= '0;
            packed_bits <= '0;
            beat_idx    <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == COLLECT && in_valid) begin
                bitmap[{elem_cnt, 1'b0} +: 2] <= cls_code;
                // Register is clear on block start, so OR-ing at the pointer is enough.
                packed_bits <= packed_bits | ({{(PACK_W-32){1'b0}}, cls_stored} << ptr);
                ptr         <= ptr + {3'b000, cls_size};
                elem_cnt    <= elem_cnt + 3'd1;
            end

            if (state_q == HEADER) begin
                beat_idx <= '0;
            end else if (state_q == PAYLOAD && out_ready) begin
                beat_idx <= beat_idx + 3'd1;
            end

            // Leaving the output phase starts a fresh block.
            if (state_q != COLLECT && state_d == COLLECT) begin
                elem_cnt    <= '0;
                ptr         <= '0;
                bitmap      <= '0;
                packed_bits <= '0;
            end
        end
    end

endmodule

// File: doc/bitmap_compressor.md
BITMAP_COMPRESSOR -- requirements
Module: bitmap_compressor

Interface
REQ-001 The block SHALL have no parameters; 8 elements per block, 32-bit element and beat width, 16-bit bitmap, all fixed.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset: the clock port is clk and the reset port is rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data holds a valid element.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 in_data  input  32  uncompressed element, element 0 first.
REQ-008 out_valid  output  1  out_data holds a valid beat.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 out_data  output  32  header beat, then packed payload beats.
REQ-011 out_last  output  1  marks the final beat of a block.

Function
REQ-012 Transfers SHALL occur only when valid && ready are both high on a rising edge.
REQ-013 Classification of element i SHALL be: value==0 -> code 2'b00, size 0; value[31:16]==0 -> 2'b10, size 16 (stores value[15:0]); otherwise -> 2'b11, size 32; code 2'b01 SHALL never be produced.
REQ-014 The code for element i SHALL occupy bitmap[2i+1:2i].
REQ-015 Element i's stored bits SHALL be placed in a 256-bit packed register starting at bit pointer P_i, with P_0=0 and P_{i+1}=P_i+size_i; P_8 (total payload bits) SHALL be 9 bits wide, range 0..256.
REQ-016 The FSM SHALL have states COLLECT, HEADER and PAYLOAD.
REQ-017 In COLLECT, in_ready SHALL be 1 and out_valid 0; each accepted element updates the bitmap, packed register and pointer; the 8th accept SHALL move the FSM to HEADER.
REQ-018 In HEADER, the outputs SHALL be out_valid=1 and out_data={16'h0000, bitmap}; out_last=1 iff P_8==0.
REQ-019 On header accept, the FSM SHALL go to COLLECT if P_8==0, else to PAYLOAD.
REQ-020 In PAYLOAD, beat k SHALL be packed[32k+31:32k], with unused high bits zero; there SHALL be N=ceil(P_8/32) beats, k=0..N-1; out_last=1 on beat N-1; after accept of beat N-1 the FSM SHALL go to COLLECT.
REQ-021 in_ready SHALL be 0 in HEADER and PAYLOAD; blocks do not overlap.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_last SHALL hold stable.
REQ-023 The first header beat SHALL be valid one cycle after the 8th input accept.
REQ-024 Packed register, bitmap and pointer SHALL clear on entry to COLLECT.

Reset
REQ-025 While rst=1: in_ready=0, out_valid=0, out_last=0, out_data=0, state=COLLECT, element count, pointer, bitmap and packed register=0.
REQ-026 Reset mid-block SHALL discard all partial input and any unsent output; the first accept after reset is element 0 of a new block.

Structure
REQ-027 Code constants (2'b00/2'b10/2'b11), size constants (0/16/32), state encoding, elements per block (8) and beat width (32) SHALL live in the shared package bitmap_pkg, also used by the decompression side.
REQ-028 Classification SHALL be a combinational sub-module bitmap_code_classify (in: 32-bit value; out: 2-bit code, 6-bit size, 32-bit stored data).

Verification
REQ-029 Eight elements of 0x00000000 -> single beat 0x00000000 with out_last=1, no payload beats.
REQ-030 Eight elements of 0x0000ABCD -> header 0x0000AAAA, then 4 beats of 0xABCDABCD, out_last on the 4th.
REQ-031 Eight elements of 0x12345678 -> header 0x0000FFFF, then 8 beats of 0x12345678, out_last on the 8th.
REQ-032 Elements {0x00001111, 0, 0xDEADBEEF, 0, 0, 0, 0, 0} -> header 0x00000032, beats 0xBEEF1111 and 0x0000DEAD (last).
REQ-033 out_ready held 0 for 3 cycles during payload beat 1 of the REQ-031 stimulus -> beat held stable, in_ready stays 0, no beat lost or duplicated.
REQ-034 rst pulsed for 1 cycle after 5 elements accepted, then the REQ-030 stimulus applied -> output exactly as REQ-030.
